alu_simd_pipelined_param: RTL and testbench

Parametrised, pipelined SIMD post-adder ALU for the PIRDSP datapath. It sums or logically combines four operand buses (W, X, Y, Z) split into NUM_SEG equal segments. A per-boundary mask fuses the segments into independent lanes. It adds an input register stage, a registered result and an accumulate feedback path, which the earlier combinational SIMD ALUs lack. It sits between the multiplier partial-product outputs and the DSP P register.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_simd_segment.sv | 37 +++
 rtl/alu_simd_pipelined_param.sv | 117 +++++++++++
 tb/tb_alu_simd_pipelined_param.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared alumode encodings, operation enum and decode for the PIRDSP SIMD post-adder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_ZSUB  = 4'b0011;
    localparam logic [3:0] ALU_NZADD = 4'b0001;
    localparam logic [3:0] ALU_NSUM  = 4'b0010;

    typedef enum logic [2:0] {
        OP_SUM,
        OP_XOR,
        OP_AND,
        OP_OR,
        OP_ZERO
    } op_e;

    function automatic op_e alu_decode(input logic [3:0] mode, input logic lor);
        op_e op;
        case (mode[3:2])
            2'b00:   op = OP_SUM;
            2'b01:   op = OP_XOR;
            2'b11:   op = lor ? OP_OR : OP_AND;
            default: op = OP_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_simd_segment.sv
// One SIMD segment: 4-operand sum with 2-bit carry in/out, plus the bitwise ops.
module alu_simd_segment
    import alu_pkg::*;
#(
    parameter int unsigned SEG_W = 9
) (
    input  op_e              op_i,
    input  logic             zinv_i,
    input  logic             rinv_i,
    input  logic [SEG_W-1:0] w_i,
    input  logic [SEG_W-1:0] x_i,
    input  logic [SEG_W-1:0] y_i,
    input  logic [SEG_W-1:0] z_i,
    input  logic [1:0]       c_i,
    output logic [SEG_W-1:0] res_o,
    output logic [1:0]       c_o
);

    logic [SEG_W-1:0] z_eff;
    logic [SEG_W+1:0] sum;

    always_comb begin
        z_eff = zinv_i ? ~z_i : z_i;
        // Four SEG_W operands plus a carry of at most 3 always fit in SEG_W+2 bits.
        sum   = {2'b00, z_eff} + {2'b00, w_i} + {2'b00, x_i} + {2'b00, y_i}
              + {{SEG_W{1'b0}}, c_i};
        c_o   = sum[SEG_W+1:SEG_W];
        case (op_i)
            OP_SUM:  res_o = rinv_i ? ~sum[SEG_W-1:0] : sum[SEG_W-1:0];
            OP_XOR:  res_o = x_i ^ z_i;
            OP_AND:  res_o = x_i & z_i;
            OP_OR:   res_o = x_i | z_i;
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_simd_pipelined_param.sv
// Two-stage SIMD post-adder: input register stage, lane-masked segment chain, registered
// result with accumulate feedback from S.
module alu_simd_pipelined_param
    import alu_pkg::*;
#(
    parameter int unsigned SEG_W   = 9,
    parameter int unsigned NUM_SEG = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic [3:0]               alumode,
    input  logic                     logic_or,
    input  logic [NUM_SEG-2:0]       boundary,
    input  logic                     acc_sel,
    input  logic                     cin,
    input  logic [SEG_W*NUM_SEG-1:0] W,
    input  logic [SEG_W*NUM_SEG-1:0] X,
    input  logic [SEG_W*NUM_SEG-1:0] Y,
    input  logic [SEG_W*NUM_SEG-1:0] Z,
    output logic [SEG_W*NUM_SEG-1:0] S,
    output logic [NUM_SEG-1:0]       carry_out,
    output logic                     out_valid
);

    localparam int unsigned DW = SEG_W * NUM_SEG;

    logic [DW-1:0]      w_q, x_q, y_q, z_q;
    logic [3:0]         mode_q;
    logic               lor_q, acc_q, cin_q, vld_q;
    logic [NUM_SEG-2:0] bnd_q;

    logic [DW-1:0]      s_q, s_d;
    logic [NUM_SEG-1:0] co_q, co_d;
    logic               ov_q;

    op_e                op;
    logic [DW-1:0]      z_op;

    always_comb begin
        op   = alu_decode(mode_q, lor_q);
        z_op = acc_q ? s_q : z_q;
    end

    // Z-T is formed as ~(~Z+T): mode[0] inverts Z, mode[1] inverts the lane result.
    for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
        logic [1:0] c_in, c_out;
        logic       top;

        if (i == 0) begin : g_first
            assign c_in = {1'b0, cin_q};
        end else begin : g_chain
            assign c_in = bnd_q[i-1] ? 2'b00 : g_seg[i-1].c_out;
        end

        if (i == NUM_SEG - 1) begin : g_msb
            assign top = 1'b1;
        end else begin : g_mid
            assign top = bnd_q[i];
        end

        alu_simd_segment #(.SEG_W(SEG_W)) u_seg (
            .op_i   (op),
            .zinv_i (mode_q[0]),
            .rinv_i (mode_q[1]),
            .w_i    (w_q[i*SEG_W +: SEG_W]),
            .x_i    (x_q[i*SEG_W +: SEG_W]),
            .y_i    (y_q[i*SEG_W +: SEG_W]),
            .z_i    (z_op[i*SEG_W +: SEG_W]),
            .c_i    (c_in),
            .res_o  (s_d[i*SEG_W +: SEG_W]),
            .c_o    (c_out)
        );

        assign co_d[i] = (mode_q == ALU_ADD) && top && c_out[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            mode_q <= '0;
            lor_q  <= 1'b0;
            bnd_q  <= '0;
            acc_q  <= 1'b0;
            cin_q  <= 1'b0;
            vld_q  <= 1'b0;
            s_q    <= '0;
            co_q   <= '0;
            ov_q   <= 1'b0;
        end else if (ce) begin
            w_q    <= W;
            x_q    <= X;
            y_q    <= Y;
            z_q    <= Z;
            mode_q <= alumode;
            lor_q  <= logic_or;
            bnd_q  <= boundary;
            acc_q  <= acc_sel;
            cin_q  <= cin;
            vld_q  <= in_valid;
            ov_q   <= vld_q;
            if (vld_q) begin
                s_q  <= s_d;
                co_q <= co_d;
            end
        end
    end

    assign S         = s_q;
    assign carry_out = co_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_alu_simd_pipelined_param.sv
// Directed-vector bench for alu_simd_pipelined_param with hand-computed expectations.
module tb_alu_simd_pipelined_param;

    localparam int unsigned SEG_W   = 9;
    localparam int unsigned NUM_SEG = 6;
    localparam int unsigned DW      = SEG_W * NUM_SEG;

    logic          clk = 1'b0;
    logic          reset, ce, in_valid, logic_or, acc_sel, cin;
    logic [3:0]    alumode;
    logic [4:0]    boundary;
    logic [DW-1:0] W, X, Y, Z, S;
    logic [5:0]    carry_out;
    logic          out_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_simd_pipelined_param #(.SEG_W(SEG_W), .NUM_SEG(NUM_SEG)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .alumode   (alumode),
        .logic_or  (logic_or),
        .boundary  (boundary),
        .acc_sel   (acc_sel),
        .cin       (cin),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .S         (S),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [3:0] m, input logic lor, input logic [4:0] b,
                           input logic acc, input logic ci, input logic [DW-1:0] w,
                           input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input logic [DW-1:0] z);
        alumode  = m;
        logic_or = lor;
        boundary = b;
        acc_sel  = acc;
        cin      = ci;
        W = w; X = x; Y = y; Z = z;
    endtask

    // Single operation, then idle one cycle so the result lands in S.
    task automatic do_op(input logic [3:0] m, input logic lor, input logic [4:0] b,
                         input logic acc, input logic ci, input logic [DW-1:0] w,
                         input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic [DW-1:0] z);
        set_ops(m, lor, b, acc, ci, w, x, y, z);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    localparam logic [DW-1:0] ALL1    = 54'h3FFFFFFFFFFFFF;
    localparam logic [DW-1:0] ONE_SEG = 54'h00201008040201;

    initial begin
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0;
        set_ops(4'b0000, 1'b0, 5'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        step(); step();
        chk("rst_S",  64'(S), 64'd0);
        chk("rst_co", 64'(carry_out), 64'd0);
        chk("rst_ov", 64'(out_valid), 64'd0);
        reset = 1'b0;
        step();

        // Full-width add with carry-in
        do_op(4'b0000, 1'b0, 5'b0, 1'b0, 1'b1, 54'd1, 54'd2, 54'd3, 54'd4);
        chk("add_S",  64'(S), 64'd11);
        chk("add_ov", 64'(out_valid), 64'd1);
        chk("add_co", 64'(carry_out), 64'd0);
        step();
        chk("idle_S",  64'(S), 64'd11);
        chk("idle_ov", 64'(out_valid), 64'd0);

        // SIMD vs fused carry
        do_op(4'b0000, 1'b0, 5'b11111, 1'b0, 1'b0, '0, ALL1, '0, ONE_SEG);
        chk("simd_S",  64'(S), 64'd0);
        chk("simd_co", 64'(carry_out), 64'b111111);
        do_op(4'b0000, 1'b0, 5'b00000, 1'b0, 1'b0, '0, ALL1, '0, 54'd1);
        chk("fused_S",  64'(S), 64'd0);
        chk("fused_co", 64'(carry_out), 64'b100000);
        do_op(4'b0000, 1'b0, 5'b00100, 1'b0, 1'b0, '0, ALL1, '0, 54'd1);
        chk("split_S",  64'(S), 64'h3FFFFFF8000000);
        chk("split_co", 64'(carry_out), 64'b000100);
        do_op(4'b0000, 1'b0, 5'b11111, 1'b0, 1'b1, '0, ALL1, '0, '0);
        chk("cin_S",  64'(S), 64'h3FFFFFFFFFFE00);
        chk("cin_co", 64'(carry_out), 64'b000001);

        // Subtract / inverted forms
        do_op(4'b0011, 1'b0, 5'b0, 1'b0, 1'b0, '0, 54'd30, '0, 54'd100);
        chk("zsub_S",  64'(S), 64'd70);
        chk("zsub_co", 64'(carry_out), 64'd0);
        do_op(4'b0011, 1'b0, 5'b11111, 1'b0, 1'b0, '0, ONE_SEG, '0, '0);
        chk("zsub_lane", 64'(S), 64'h3FFFFFFFFFFFFF);
        do_op(4'b0001, 1'b0, 5'b0, 1'b0, 1'b0, '0, 54'd10, '0, 54'd5);
        chk("nzadd_S", 64'(S), 64'd4);
        do_op(4'b0010, 1'b0, 5'b0, 1'b0, 1'b0, '0, 54'd1, '0, 54'd1);
        chk("nsum_S", 64'(S), 64'h3FFFFFFFFFFFFD);

        // Logic ops
        do_op(4'b1100, 1'b1, 5'b0, 1'b0, 1'b0, '0, 54'hF0, '0, 54'h0F);
        chk("or_S",  64'(S), 64'hFF);
        chk("or_co", 64'(carry_out), 64'd0);
        do_op(4'b1111, 1'b0, 5'b0, 1'b0, 1'b0, '0, 54'hF0, '0, 54'h3C);
        chk("and_S", 64'(S), 64'h30);
        do_op(4'b0110, 1'b0, 5'b0, 1'b0, 1'b0, '0, 54'hF0, '0, 54'h3C);
        chk("xor_S", 64'(S), 64'hCC);
        do_op(4'b1000, 1'b0, 5'b0, 1'b0, 1'b0, '0, 54'hF0, '0, 54'h3C);
        chk("bad_S", 64'(S), 64'd0);

        // Accumulate, back to back
        do_op(4'b0000, 1'b0, 5'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        chk("acc_load", 64'(S), 64'd0);
        set_ops(4'b0000, 1'b0, 5'b0, 1'b1, 1'b0, '0, 54'd5, '0, 54'd999);
        in_valid = 1'b1;
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) in_valid = 1'b0;
            step();
            chk("acc_seq", 64'(S), 64'(5 * k));
        end

        // ce stall mid-accumulate (S=20 here)
        in_valid = 1'b1;
        step();
        step();
        chk("stall_pre", 64'(S), 64'd25);
        step();
        chk("stall_pre2", 64'(S), 64'd30);
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_S",  64'(S), 64'd30);
            chk("stall_ov", 64'(out_valid), 64'd1);
        end
        ce = 1'b1;
        step();
        chk("resume1", 64'(S), 64'd35);
        step();
        chk("resume2", 64'(S), 64'd40);
        in_valid = 1'b0;
        step();
        chk("resume3", 64'(S), 64'd45);
        step();
        chk("resume_hold", 64'(S), 64'd45);
        chk("resume_ov",   64'(out_valid), 64'd0);

        // Asynchronous reset mid-accumulate
        in_valid = 1'b1;
        step();
        step();
        chk("pre_rst", 64'(S), 64'd50);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_S",  64'(S), 64'd0);
        chk("arst_co", 64'(carry_out), 64'd0);
        chk("arst_ov", 64'(out_valid), 64'd0);
        step();
        chk("rst_hold_S",  64'(S), 64'd0);
        chk("rst_hold_ov", 64'(out_valid), 64'd0);
        reset = 1'b0;
        do_op(4'b0000, 1'b0, 5'b0, 1'b1, 1'b0, '0, 54'd5, '0, 54'd777);
        chk("post_rst_acc", 64'(S), 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
